bcd_countdown_timer: RTL

- Downstream consumer of the periodic one-cycle `enable` tick from the pulse generator; that tick is treated as a 1 s timebase.
- Holds an mm:ss countdown in packed BCD, controlled by start/pause/clear/load pulses from the button-debounce stage.
- Drives the 7-segment display stage with `time_bcd` and signals expiry with a one-cycle `done` pulse.

---
 rtl/bcd_countdown_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - mm:ss packed-BCD countdown timer clocked by a 1 s tick strobe
// Optional macro TIMER_ALARM_EN adds a blinking alarm output and a 10-tick auto-return to IDLE.
module bcd_countdown_timer #(
  parameter int MAX_MIN = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done,
`ifdef TIMER_ALARM_EN
  output logic        alarm,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);
  localparam logic [6:0] MAX_MIN7 = 7'(MAX_MIN);

  state_e      state_q;
  logic [15:0] time_q;
  logic        done_q;
  logic [3:0]  ld_mt, ld_mo, ld_st, ld_so;
  logic [6:0]  ld_min;
  logic [15:0] clamp_time;
  logic [15:0] dec_time;

`ifdef TIMER_ALARM_EN
  logic        alarm_q;
  logic [3:0]  acnt_q;
`endif

  // Digit clamping first, then the minutes limit on the clamped decimal value.
  always_comb begin
    ld_mt  = (load_bcd[15:12] > 4'd9) ? 4'd9 : load_bcd[15:12];
    ld_mo  = (load_bcd[11:8]  > 4'd9) ? 4'd9 : load_bcd[11:8];
    ld_st  = (load_bcd[7:4]   > 4'd5) ? 4'd5 : load_bcd[7:4];
    ld_so  = (load_bcd[3:0]   > 4'd9) ? 4'd9 : load_bcd[3:0];
    ld_min = 7'(ld_mt) * 7'd10 + 7'(ld_mo);
    if (ld_min > MAX_MIN7) begin
      clamp_time = {MAX_TENS, MAX_ONES, ld_st, ld_so};
    end else begin
      clamp_time = {ld_mt, ld_mo, ld_st, ld_so};
    end
  end

  always_comb begin
    dec_time = time_q;
    if (time_q[3:0] != 4'd0) begin
      dec_time[3:0] = time_q[3:0] - 4'd1;
    end else begin
      dec_time[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) begin
        dec_time[7:4] = time_q[7:4] - 4'd1;
      end else begin
        dec_time[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) begin
          dec_time[11:8] = time_q[11:8] - 4'd1;
        end else begin
          dec_time[11:8]  = 4'd9;
          dec_time[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q  <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
`ifdef TIMER_ALARM_EN
      alarm_q <= 1'b0;
      acnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        time_q  <= '0;
        state_q <= IDLE;
      end else if (load) begin
        if (state_q != RUN) begin
          time_q  <= clamp_time;
          state_q <= IDLE;
        end
      end else if (pause) begin
        if (state_q == RUN) state_q <= PAUSED;
      end else if (start) begin
        if ((state_q == IDLE || state_q == PAUSED) && time_q != '0) state_q <= RUN;
      end else if (tick) begin
        if (state_q == RUN) begin
          time_q <= dec_time;
          if (dec_time == '0) begin
            state_q <= EXPIRED;
            done_q  <= 1'b1;
`ifdef TIMER_ALARM_EN
            alarm_q <= 1'b1;
            acnt_q  <= '0;
`endif
          end
`ifdef TIMER_ALARM_EN
        end else if (state_q == EXPIRED) begin
          if (acnt_q == 4'd9) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end else begin
            acnt_q  <= acnt_q + 4'd1;
            alarm_q <= ~alarm_q;
          end
`endif
        end
      end
    end
  end

  assign time_bcd = time_q;
  assign state    = state_q;
  assign running  = (state_q == RUN);
  assign done     = done_q;
`ifdef TIMER_ALARM_EN
  // Blink phase is only meaningful while expired; elsewhere the output is held low.
  assign alarm    = alarm_q & (state_q == EXPIRED);
`endif

endmodule
